// File: rtl/oarb_pkg.sv
// oarb_pkg: shared sizing and FSM encoding for the output-port arbiter
package oarb_pkg;
    localparam int PORT = 3;
    localparam int PKTW = 15;
    typedef enum logic {OA_IDLE, OA_GNT} oa_state_e;
endpackage

// File: rtl/oarb_rr_pick.sv
// oarb_rr_pick: round-robin first-set search over elig starting at ptr, wrapping to 0
module oarb_rr_pick #(
    parameter int NIN = 4,
    parameter int PW = (NIN > 1) ? $clog2(NIN) : 1
) (
    input  logic [NIN-1:0] elig,
    input  logic [PW-1:0]  ptr,
    output logic [NIN-1:0] onehot,
    output logic [PW-1:0]  idx,
    output logic           any
);
    logic [PW-1:0] j;
    always_comb begin
        onehot = '0;
        idx = '0;
        any = 1'b0;
        j = '0;
        for (int k = 0; k < NIN; k++) begin
            j = PW'((int'(ptr) + k) % NIN);
            if (!any && elig[j]) begin
                any = 1'b1;
                idx = j;
                onehot[j] = 1'b1;
            end
        end
    end
endmodule

// File: rtl/oarb.sv
// oarb: per-output round-robin arbiter; one-cycle ack to the winning ib, winner's packet registered onto pkto
module oarb #(
    parameter int NIN = oarb_pkg::PORT + 1,
    parameter int PKTW = oarb_pkg::PKTW
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NIN-1:0]          req,
    input  logic [NIN*(PKTW+1)-1:0] pkti,
    input  logic                    full,
    output logic [NIN-1:0]          ack,
    output logic [PKTW:0]           pkto
);
    import oarb_pkg::*;
    localparam int PW = (NIN > 1) ? $clog2(NIN) : 1;
    oa_state_e state, state_d;
    logic [PW-1:0] ptr, ptr_d, w, w_d, idx;
    logic [NIN-1:0] mask, mask_d, ack_d, onehot, elig;
    logic [PKTW:0] pkto_d;
    logic any;
    // the last winner's req lags its pop by a cycle, so it sits out one IDLE cycle
    assign elig = req & ~mask;
    oarb_rr_pick #(.NIN(NIN), .PW(PW)) u_pick (
        .elig(elig),
        .ptr(ptr),
        .onehot(onehot),
        .idx(idx),
        .any(any)
    );
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= OA_IDLE;
            ptr <= '0;
            mask <= '0;
            ack <= '0;
            pkto <= '0;
            w <= '0;
        end else begin
            state <= state_d;
            ptr <= ptr_d;
            mask <= mask_d;
            ack <= ack_d;
            pkto <= pkto_d;
            w <= w_d;
        end
    end
    always_comb state_d = (state == OA_GNT) ? OA_IDLE : (any && !full) ? OA_GNT : OA_IDLE;
    always_comb begin
        ack_d = (state == OA_IDLE && any && !full) ? onehot : '0;
        w_d = (state == OA_IDLE) ? idx : w;
        mask_d = (state == OA_GNT) ? ack : '0;
        ptr_d = (state == OA_GNT) ? ((w == PW'(NIN - 1)) ? '0 : w + PW'(1)) : ptr;
        pkto_d = (state == OA_GNT) ? pkti[int'(w)*(PKTW+1) +: PKTW+1] : '0;
    end
endmodule

// File: tb/tb_oarb.sv
// tb_oarb: vector table, hand-written corner sequences and a randomized run against a behavioural arbiter model
module tb_oarb;
    localparam int NIN = 4;
    localparam int PW = oarb_pkg::PKTW + 1;

    logic clk = 1'b0;
    logic rst;
    logic [NIN-1:0] req, ack, prev_ack;
    logic full;
    logic [NIN*PW-1:0] pkti;
    logic [PW-1:0] pkto;
    int checks = 0;
    int failures = 0;

    int m_ptr, m_mask, m_win;
    bit m_busy;
    logic [NIN-1:0] e_ack;
    logic [PW-1:0] e_pkto;

    typedef struct {
        logic [NIN-1:0] r;
        logic f;
        logic [NIN-1:0] a;
        logic [PW-1:0] p;
    } vec_t;
    vec_t tbl[14];
    int order[$];

    always #5 clk = ~clk;

    oarb #(.NIN(NIN), .PKTW(oarb_pkg::PKTW)) dut (
        .clk(clk),
        .rst(rst),
        .req(req),
        .pkti(pkti),
        .full(full),
        .ack(ack),
        .pkto(pkto)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_ptr = 0;
        m_mask = -1;
        m_win = 0;
        m_busy = 0;
        prev_ack = '0;
    endtask

    // one arbitration cycle from the rules: a grant is followed by a forward cycle, then the winner sits out once
    task automatic model_step();
        e_ack = '0;
        e_pkto = '0;
        if (m_busy) begin
            e_pkto = pkti[m_win*PW +: PW];
            m_ptr = (m_win + 1) % NIN;
            m_mask = m_win;
            m_busy = 0;
        end else begin
            if (!full)
                for (int k = 0; k < NIN; k++) begin
                    int i;
                    i = (m_ptr + k) % NIN;
                    if (req[i] && i != m_mask) begin
                        e_ack[i] = 1'b1;
                        m_win = i;
                        m_busy = 1;
                        break;
                    end
                end
            m_mask = -1;
        end
    endtask

    task automatic cyc(input logic [NIN-1:0] r, input logic f, input string name);
        req = r;
        full = f;
        model_step();
        @(posedge clk);
        #1;
        chk({name, "_ack"}, 64'(ack), 64'(e_ack));
        chk({name, "_pkto"}, 64'(pkto), 64'(e_pkto));
        chk({name, "_onehot"}, 64'($countones(ack) <= 1), 64'd1);
        chk({name, "_gap"}, 64'((|ack) && (|prev_ack)), 64'd0);
        prev_ack = ack;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req = '0;
        full = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("reset_ack", 64'(ack), 64'd0);
        chk("reset_pkto", 64'(pkto), 64'd0);
        rst = 1'b0;
    endtask

    initial begin
        tbl[0]  = '{4'b0100, 1'b0, 4'b0100, 16'h0000};
        tbl[1]  = '{4'b0100, 1'b0, 4'b0000, 16'h5A5A};
        tbl[2]  = '{4'b0100, 1'b0, 4'b0000, 16'h0000};
        tbl[3]  = '{4'b0100, 1'b0, 4'b0100, 16'h0000};
        tbl[4]  = '{4'b0000, 1'b0, 4'b0000, 16'h5A5A};
        tbl[5]  = '{4'b1111, 1'b0, 4'b1000, 16'h0000};
        tbl[6]  = '{4'b1111, 1'b0, 4'b0000, 16'hDDD3};
        tbl[7]  = '{4'b1111, 1'b0, 4'b0001, 16'h0000};
        tbl[8]  = '{4'b1111, 1'b1, 4'b0000, 16'hA0A0};
        tbl[9]  = '{4'b1111, 1'b1, 4'b0000, 16'h0000};
        tbl[10] = '{4'b1111, 1'b1, 4'b0000, 16'h0000};
        tbl[11] = '{4'b1111, 1'b0, 4'b0010, 16'h0000};
        tbl[12] = '{4'b1111, 1'b1, 4'b0000, 16'hB0B1};
        tbl[13] = '{4'b0000, 1'b0, 4'b0000, 16'h0000};

        pkti = {16'hDDD3, 16'h5A5A, 16'hB0B1, 16'hA0A0};
        do_reset();
        for (int i = 0; i < 14; i++) begin
            req = tbl[i].r;
            full = tbl[i].f;
            @(posedge clk);
            #1;
            chk($sformatf("tbl%0d_ack", i), 64'(ack), 64'(tbl[i].a));
            chk($sformatf("tbl%0d_pkto", i), 64'(pkto), 64'(tbl[i].p));
        end

        do_reset();
        pkti = {$urandom, $urandom};
        order.delete();
        for (int i = 0; i < 16; i++) begin
            cyc(4'b1111, 1'b0, "rot");
            for (int b = 0; b < NIN; b++)
                if (ack[b]) order.push_back(b);
        end
        chk("rot_count", 64'(order.size()), 64'd8);
        foreach (order[j]) chk($sformatf("rot_order%0d", j), 64'(order[j]), 64'(j % NIN));

        do_reset();
        cyc(4'b1111, 1'b0, "pre_rst");
        chk("pre_rst_gnt", 64'(ack), 64'b0001);
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst_ack", 64'(ack), 64'd0);
        chk("async_rst_pkto", 64'(pkto), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        cyc(4'b0001, 1'b0, "post_rst");
        chk("post_rst_gnt0", 64'(ack), 64'b0001);

        do_reset();
        for (int i = 0; i < 10000; i++) begin
            pkti = {$urandom, $urandom};
            cyc(4'($urandom), ($urandom_range(0, 3) == 0), "rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
